// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: shared constants and gray-code helpers for the async FIFO
// pointer controller (fifo_ptr_ctrl) and its synchroniser.
//   MODE_WR / MODE_RD : side selection for fifo_ptr_ctrl.MODE
//   bin2gray          : binary -> reflected gray code
//   gray2bin          : gray -> binary, XOR prefix from the MSB of a w-bit word
package fifo_ptr_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bits at or above w are treated as absent, so the prefix starts at bit w-1.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] b;
        logic        acc;
        b   = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if: pointer/flag bundle for one side of an async FIFO.
//   op          : push (write side) or pop (read side) request
//   remote_gray : gray pointer arriving from the other clock domain
//   binary/gray : local pointer, binary and gray, with wrap bit
//   addr        : memory address (binary without wrap bit)
//   status      : full (write side) or empty (read side)
//   almost      : almost-full / almost-empty
//   level       : fill level 0..2^ADDR
//   err         : sticky overflow/underflow flag (0 unless FIFO_PTR_ERR_EN)
// master: the user of the controller; slave: fifo_ptr_ctrl itself.
interface fifo_ptr_ctrl_if #(parameter int ADDR = 5);
    logic            op;
    logic [ADDR:0]   remote_gray;
    logic [ADDR:0]   binary;
    logic [ADDR:0]   gray;
    logic [ADDR-1:0] addr;
    logic            status;
    logic            almost;
    logic [ADDR:0]   level;
    logic            err;

    modport master (output op, remote_gray,
                    input  binary, gray, addr, status, almost, level, err);
    modport slave  (input  op, remote_gray,
                    output binary, gray, addr, status, almost, level, err);
endinterface

// File: rtl/gray_sync_chain.sv
// gray_sync_chain: STAGES-deep flop chain bringing a gray-coded pointer into
// the local clock domain. Gray coding guarantees at most one bit is in flight,
// so the whole word can be synchronised bit-parallel.
//   clk, reset_b : local clock, async active-low reset (flops clear to 0)
//   i_d          : asynchronous gray input
//   o_q          : synchronised output (last stage)
module gray_sync_chain #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) r_sync <= '0;
        else          r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer and flag controller for one side of an async FIFO.
// MODE=MODE_WR drives the full flag, MODE=MODE_RD the empty flag. The remote
// gray pointer is synchronised locally and all flags/level are computed from
// the next-state local pointer, then registered (one-cycle latency).
//   clk, reset_b : local clock, async active-low reset
//   bus (slave)  : op / remote_gray in; binary, gray, addr, status, almost,
//                  level, err out
// Optional build macro: FIFO_PTR_ERR_EN enables the sticky err flag.
module fifo_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR        = 5,
    parameter int MODE        = MODE_WR,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 4
) (
    input  logic           clk,
    input  logic           reset_b,
    fifo_ptr_ctrl_if.slave bus
);

    localparam int PW = ADDR + 1;
    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t DEPTH    = ptr_t'(1) << ADDR;
    localparam ptr_t TH       = ptr_t'(ALMOST_TH);
    // The read side comes out of reset empty (and therefore almost-empty).
    localparam logic RST_FLAG = (MODE == MODE_RD);

    ptr_t r_binary, r_gray, r_level;
    logic r_status, r_almost;

    ptr_t w_rsync, w_rbin;
    ptr_t w_bin_next, w_gray_next, w_level_next;
    logic w_inc, w_stat_next, w_almost_next;

    gray_sync_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .i_d     (bus.remote_gray),
        .o_q     (w_rsync)
    );

    assign w_rbin      = ptr_t'(gray2bin(32'(w_rsync), PW));
    assign w_inc       = bus.op & ~r_status;
    assign w_bin_next  = r_binary + ptr_t'(w_inc);
    assign w_gray_next = ptr_t'(bin2gray(32'(w_bin_next)));

    generate
        if (MODE == MODE_WR) begin : g_wr
            // Full when the write pointer is exactly one lap ahead: in gray
            // that is the remote pointer with its top two bits inverted.
            assign w_stat_next   = (w_gray_next == {~w_rsync[ADDR:ADDR-1], w_rsync[ADDR-2:0]});
            assign w_level_next  = w_bin_next - w_rbin;
            assign w_almost_next = (w_level_next >= DEPTH - TH);
        end else begin : g_rd
            assign w_stat_next   = (w_gray_next == w_rsync);
            assign w_level_next  = w_rbin - w_bin_next;
            assign w_almost_next = (w_level_next <= TH);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_binary <= '0;
            r_gray   <= '0;
            r_level  <= '0;
            r_status <= RST_FLAG;
            r_almost <= RST_FLAG;
        end else begin
            r_binary <= w_bin_next;
            r_gray   <= w_gray_next;
            r_level  <= w_level_next;
            r_status <= w_stat_next;
            r_almost <= w_almost_next;
        end
    end

`ifdef FIFO_PTR_ERR_EN
    logic r_err;

    // Set by any request that arrives while the side is full/empty.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)                r_err <= 1'b0;
        else if (bus.op & r_status)  r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.binary = r_binary;
    assign bus.gray   = r_gray;
    assign bus.addr   = r_binary[ADDR-1:0];
    assign bus.status = r_status;
    assign bus.almost = r_almost;
    assign bus.level  = r_level;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: write-side and read-side controllers (ADDR=3, 2 sync
// stages) checked every cycle against a modulo-arithmetic model of the FIFO
// occupancy, plus directed checks with hand-computed literal values.
module tb_fifo_ptr_ctrl;
    import fifo_ptr_pkg::*;

    localparam int A    = 3;
    localparam int S    = 2;
    localparam int D    = 1 << A;
    localparam int W2   = 2 * D;
    localparam int TH_W = 2;
    localparam int TH_R = 4;
`ifdef FIFO_PTR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.ADDR(A)) bw ();
    fifo_ptr_ctrl_if #(.ADDR(A)) br ();

    fifo_ptr_ctrl #(.ADDR(A), .MODE(MODE_WR), .SYNC_STAGES(S), .ALMOST_TH(TH_W)) dut_w (
        .clk(clk), .reset_b(reset_b), .bus(bw));
    fifo_ptr_ctrl #(.ADDR(A), .MODE(MODE_RD), .SYNC_STAGES(S), .ALMOST_TH(TH_R)) dut_r (
        .clk(clk), .reset_b(reset_b), .bus(br));

    bit op_w, op_r;
    int rem_w, rem_r;   // remote pointers in binary; driven as gray
    assign bw.op          = op_w;
    assign br.op          = op_r;
    assign bw.remote_gray = (A+1)'(rem_w ^ (rem_w >> 1));
    assign br.remote_gray = (A+1)'(rem_r ^ (rem_r >> 1));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: one pointer per side plus the remote value seen S edges ago.
    typedef struct packed {
        int ptr;
        int lvl;
        bit st;
        bit al;
        bit er;
    } ms_t;

    function automatic ms_t mreset(input bit rd);
        ms_t s;
        s.ptr = 0; s.lvl = 0; s.er = 1'b0; s.st = rd; s.al = rd;
        return s;
    endfunction

    function automatic ms_t mstep(input ms_t s, input bit op, input int rb, input bit rd, input int th);
        ms_t n;
        n.ptr = (s.ptr + ((op && !s.st) ? 1 : 0)) % W2;
        n.lvl = rd ? (rb - n.ptr + W2) % W2 : (n.ptr - rb + W2) % W2;
        n.st  = rd ? (n.lvl == 0) : (n.lvl == D);
        n.al  = rd ? (n.lvl <= th) : (n.lvl >= D - th);
        n.er  = ERR_EN && (s.er || (op && s.st));
        return n;
    endfunction

    ms_t mw, mr;
    int hw[S];
    int hr[S];

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mw <= mreset(1'b0);
            mr <= mreset(1'b1);
            for (int i = 0; i < S; i++) begin
                hw[i] <= 0;
                hr[i] <= 0;
            end
        end else begin
            mw <= mstep(mw, op_w, hw[0], 1'b0, TH_W);
            mr <= mstep(mr, op_r, hr[0], 1'b1, TH_R);
            for (int i = 0; i < S - 1; i++) begin
                hw[i] <= hw[i+1];
                hr[i] <= hr[i+1];
            end
            hw[S-1] <= rem_w;
            hr[S-1] <= rem_r;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("w.binary", 32'(bw.binary), mw.ptr);
            chk("w.gray",   32'(bw.gray),   mw.ptr ^ (mw.ptr >> 1));
            chk("w.addr",   32'(bw.addr),   mw.ptr % D);
            chk("w.full",   32'(bw.status), 32'(mw.st));
            chk("w.almost", 32'(bw.almost), 32'(mw.al));
            chk("w.level",  32'(bw.level),  mw.lvl);
            chk("w.err",    32'(bw.err),    32'(mw.er));
            chk("r.binary", 32'(br.binary), mr.ptr);
            chk("r.gray",   32'(br.gray),   mr.ptr ^ (mr.ptr >> 1));
            chk("r.addr",   32'(br.addr),   mr.ptr % D);
            chk("r.empty",  32'(br.status), 32'(mr.st));
            chk("r.almost", 32'(br.almost), 32'(mr.al));
            chk("r.level",  32'(br.level),  mr.lvl);
            chk("r.err",    32'(br.err),    32'(mr.er));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reset asserted and released between clock edges.
    task automatic mid_reset();
        #2 reset_b = 1'b0;
        #1;
    endtask

    logic [31:0] gtab [16];
    logic [31:0] prev_g;
    int pw, pr;

    initial begin
        gtab = '{32'h0, 32'h1, 32'h3, 32'h2, 32'h6, 32'h7, 32'h5, 32'h4,
                 32'hC, 32'hD, 32'hF, 32'hE, 32'hA, 32'hB, 32'h9, 32'h8};
        op_w = 1'b0; op_r = 1'b0; rem_w = 0; rem_r = 0;
        #1 reset_b = 1'b0;
        #1 cmp_en = 1'b1;
        #1;
        chk("rst.w.binary", 32'(bw.binary), 0);
        chk("rst.w.gray",   32'(bw.gray),   0);
        chk("rst.w.level",  32'(bw.level),  0);
        chk("rst.w.full",   32'(bw.status), 0);
        chk("rst.w.almost", 32'(bw.almost), 0);
        chk("rst.r.empty",  32'(br.status), 1);
        chk("rst.r.almost", 32'(br.almost), 1);
        chk("rst.r.level",  32'(br.level),  0);
        @(negedge clk);
        #2 reset_b = 1'b1;

        // Fill the write side with the remote pointer held at 0.
        op_w = 1'b1;
        for (int i = 1; i <= D; i++) begin
            tick();
            chk("fill.level",  32'(bw.level),  i);
            chk("fill.almost", 32'(bw.almost), (i >= D - TH_W) ? 1 : 0);
            chk("fill.full",   32'(bw.status), (i == D) ? 1 : 0);
        end
        chk("fill.binary", 32'(bw.binary), 8);
        chk("fill.gray",   32'(bw.gray),   12);
        tick();
        chk("ovf.binary", 32'(bw.binary), 8);
        chk("ovf.err",    32'(bw.err),    32'(ERR_EN));
        op_w = 1'b0;

        // Reset between edges while full.
        mid_reset();
        chk("mrst.full",   32'(bw.status), 0);
        chk("mrst.binary", 32'(bw.binary), 0);
        chk("mrst.level",  32'(bw.level),  0);
        chk("mrst.err",    32'(bw.err),    0);
        #2 reset_b = 1'b1;
        op_w = 1'b1;
        tick();
        op_w = 1'b0;
        chk("post.binary", 32'(bw.binary), 1);
        chk("post.gray",   32'(bw.gray),   1);

        // Remote step to 4 on the read side: seen exactly 3 edges later.
        rem_r = 4;
        tick(); chk("sync.e1", 32'(br.status), 1);
        tick(); chk("sync.e2", 32'(br.status), 1);
        tick();
        chk("sync.e3",     32'(br.status), 0);
        chk("sync.level",  32'(br.level),  4);
        chk("sync.almost", 32'(br.almost), 1);
        op_r = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("pop.level", 32'(br.level),  4 - i);
            chk("pop.empty", 32'(br.status), (i == 4) ? 1 : 0);
        end
        tick();
        chk("udf.binary", 32'(br.binary), 4);
        chk("udf.empty",  32'(br.status), 1);
        chk("udf.err",    32'(br.err),    32'(ERR_EN));
        op_r = 1'b0;

        // Gray sequence with the remote pointer trailing the local one.
        mid_reset();
        #2 reset_b = 1'b1;
        rem_w = 0; rem_r = 0;
        op_w = 1'b1;
        prev_g = 32'(bw.gray);
        for (int i = 1; i <= 2 * D + 1; i++) begin
            tick();
            rem_w = mw.ptr;
            chk("gseq.gray", 32'(bw.gray), gtab[i % 16]);
            chk("gseq.step", 32'($countones(32'(bw.gray) ^ prev_g)), 1);
            if (i == 2 * D) chk("gseq.wrap", 32'(bw.binary), 0);
            prev_g = 32'(bw.gray);
        end
        op_w = 1'b0;

        // Random traffic with the two sides cross-connected.
        mid_reset();
        #2 reset_b = 1'b1;
        rem_w = 0; rem_r = 0;
        for (int c = 0; c < 4000; c++) begin
            pw = ((c / 150) % 2 == 0) ? 80 : 25;
            pr = ((c / 150) % 2 == 0) ? 25 : 80;
            op_w = ($urandom_range(0, 99) < pw);
            op_r = ($urandom_range(0, 99) < pr);
            tick();
            rem_w = mr.ptr;
            rem_r = mw.ptr;
        end
        op_w = 1'b0; op_r = 1'b0;
        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Parametrised pointer-and-flag controller for one side of an asynchronous FIFO. It replaces the plain binary/gray pointer counter and is instantiated twice per FIFO. MODE selects the write side (full flag) or the read side (empty flag). Each instance synchronises the opposite side's gray pointer into its own clock domain and derives its flag, an almost flag and a fill level from it.

Parameters:
ADDR, 5, address width; FIFO depth = 2^ADDR; legal range ADDR >= 2.
MODE, 0, 0 = write side (status = full), 1 = read side (status = empty).
SYNC_STAGES, 2, flop stages in the remote-pointer synchroniser; legal range >= 2.
ALMOST_TH, 4, threshold for the almost flag; legal range 1..2^ADDR-1.

Ports:
clk  in  1  local domain clock.
reset_b  in  1  asynchronous, active-low reset.
op  in  1  push request (MODE=0) or pop request (MODE=1).
remote_gray  in  ADDR+1  gray pointer from the other clock domain (asynchronous).
binary  out  ADDR+1  registered binary pointer, including the wrap bit.
gray  out  ADDR+1  registered gray pointer, sent to the other domain.
addr  out  ADDR  memory address, equal to binary[ADDR-1:0].
status  out  1  registered full flag (MODE=0) or empty flag (MODE=1).
almost  out  1  registered almost-full (MODE=0) or almost-empty (MODE=1) flag.
level  out  ADDR+1  registered fill level, 0..2^ADDR.
err  out  1  sticky overflow/underflow flag; tied to 0 unless the optional feature is enabled.

Behaviour:
- Reset (asynchronous, with no clock required):
  - binary = 0, gray = 0, level = 0, err = 0, all synchroniser flops = 0.
  - MODE=0: status = 0, almost = 0.
  - MODE=1: status = 1, almost = 1.
- Increment:
  - inc = op & ~status.
  - binary_next = binary + inc, modulo 2^(ADDR+1); the pointer wraps from 2^(ADDR+1)-1 to 0.
  - gray_next = (binary_next >> 1) ^ binary_next.
  - Both are registered on the same edge. gray changes by exactly one bit per increment.
- op while status=1: ignored; the pointers hold.
- Synchroniser: remote_gray passes through SYNC_STAGES flops to give rsync. rbin = gray2bin(rsync).
- Flags are computed from the next-state values and registered (one-cycle latency):
  - MODE=0: full_next = (gray_next == {~rsync[ADDR:ADDR-1], rsync[ADDR-2:0]}); level_next = binary_next - rbin.
  - MODE=1: empty_next = (gray_next == rsync); level_next = rbin - binary_next.
  - MODE=0: almost_next = (level_next >= 2^ADDR - ALMOST_TH).
  - MODE=1: almost_next = (level_next <= ALMOST_TH).
- Latency:
  - A local op is reflected in status, level and almost on the next edge.
  - A remote pointer change is reflected SYNC_STAGES+1 edges after it becomes stable.
  - Flags are therefore pessimistic: full or empty may deassert late, but never early.
- Simultaneous local op and remote change: both are applied. The local effect appears at +1 cycle; the remote effect appears per the synchroniser latency above.
- Reset mid-operation: all outputs return to their reset values immediately. The system resets both domains together; the block does not handle a one-sided reset.

Optional Feature:
Macro FIFO_PTR_ERR_EN.
- Defined: err is set on the edge where op=1 and status=1 (overflow attempt in MODE=0, underflow attempt in MODE=1). err stays set until reset_b.
- Undefined: err is a constant 0 and no flop is inferred.
- Pointer behaviour is identical in both builds.

Decomposition:
- Package fifo_ptr_pkg holds:
  - constants MODE_WR = 0 and MODE_RD = 1;
  - function bin2gray;
  - function gray2bin (XOR prefix from the MSB), parametrised on width.
- Sub-module gray_sync_chain (parameters WIDTH, STAGES; reset via reset_b) implements the remote-pointer synchroniser.

Test Plan:
- Reset, ADDR=3: reset_b=0 -> binary=0, gray=0, level=0; MODE=0 gives status=0, almost=0; MODE=1 gives status=1, almost=1.
- Fill, MODE=0, ADDR=3, remote_gray=0: 8 pushes -> full=1 after the 8th edge, binary=4'b1000, gray=4'b1100, level=8. A 9th push leaves binary=8 and sets err=1 (when FIFO_PTR_ERR_EN is defined).
- Gray sequence, MODE=0, remote tracking local: 16 increments -> gray = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0. Check one bit changes per step and binary wraps 15 -> 0.
- Remote sync, MODE=1, ADDR=3, SYNC_STAGES=2, ALMOST_TH=4: remote_gray steps 0 -> 4'b0110 (binary 4) -> empty deasserts exactly 3 edges later with level=4 and almost=1. Then 4 pops -> empty=1 and level=0 one edge after the 4th pop. A 5th pop is ignored.
- Almost-full, MODE=0, ADDR=3, ALMOST_TH=2: pushes with remote=0 -> almost rises on the edge where level reaches 6, full stays 0 until level=8.
- Reset mid-operation: with full=1 and level=8, assert reset_b between clock edges -> status=0, binary=0, level=0, err=0 immediately. Release, then one push -> binary=1, gray=1.
